// File: rtl/file_multi.sv
// Parametrised two-port register file with swap, range flag and init sweep.
// Port A executes commands; port B is a free-running registered read.
module file_multi #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_file_en,
    input  logic [3:0]        i_operation,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_ac,
    input  logic [ADDR_W-1:0] i_addr_b,
    output logic [DATA_W-1:0] o_file_out,
    output logic [DATA_W-1:0] o_file_out_b,
    output logic              o_out_valid,
    output logic              o_addr_err,
    output logic              o_busy
);
    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LIM  = (ADDR_W+1)'(DEPTH);
    localparam logic [CW-1:0]   LAST = CW'(DEPTH - 1);

    typedef enum logic {S_SWEEP, S_IDLE} state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nx;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_file_out;
    logic [DATA_W-1:0] r_file_out_b;
    logic              r_out_valid;
    logic              r_addr_err;

    logic              w_a_in;
    logic              w_b_in;
    logic [CW-1:0]     w_a_idx;
    logic [CW-1:0]     w_b_idx;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic              w_op_rd;
    logic              w_op_wr;
    logic              w_op_sw;
    logic              w_op_in;
    logic              w_we;
    logic [CW-1:0]     w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_ld;
    logic [DATA_W-1:0] w_ld_val;
    logic              w_err;
    logic              w_b_hit;

    assign w_a_in  = {1'b0, i_addr} < LIM;
    assign w_b_in  = {1'b0, i_addr_b} < LIM;
    assign w_a_idx = i_addr[CW-1:0];
    assign w_b_idx = i_addr_b[CW-1:0];
    assign w_rd_a  = w_a_in ? r_mem[w_a_idx] : '0;
    assign w_rd_b  = w_b_in ? r_mem[w_b_idx] : '0;

    assign w_op_rd = i_operation == 4'b0000;
    assign w_op_wr = i_operation == 4'b0001;
    assign w_op_sw = i_operation == 4'b0010;
    assign w_op_in = i_operation == 4'b0011;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_SWEEP;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_we       = 1'b0;
        w_waddr    = w_a_idx;
        w_wdata    = i_ac;
        w_ld       = 1'b0;
        w_ld_val   = i_ac;
        w_err      = 1'b0;
        unique case (r_state)
            S_SWEEP: begin
                w_we    = 1'b1;
                w_waddr = r_cnt;
                w_wdata = DATA_W'(r_cnt);
                if (r_cnt == LAST) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (i_file_en) begin
                    unique case (1'b1)
                        w_op_rd: begin
                            w_ld     = 1'b1;
                            w_ld_val = w_rd_a;
                            w_err    = !w_a_in;
                        end
                        w_op_wr: begin
                            w_we  = w_a_in;
                            w_err = !w_a_in;
                        end
                        w_op_sw: begin
                            w_ld     = 1'b1;
                            w_ld_val = w_rd_a;
                            w_we     = w_a_in;
                            w_err    = !w_a_in;
                        end
                        w_op_in: begin
                            w_state_nx = S_SWEEP;
                            w_cnt_nx   = '0;
                        end
                        default: w_ld = 1'b1;
                    endcase
                end
            end
            default: ;
        endcase
    end

    // Port B sees the value being written this edge (write-first).
    assign w_b_hit = w_we && w_b_in && (w_waddr == w_b_idx);

    always_ff @(posedge i_clk) begin
        if (w_we && !i_rst) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_file_out   <= '0;
            r_file_out_b <= '0;
            r_out_valid  <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            if (w_ld) begin
                r_file_out <= w_ld_val;
            end
            r_file_out_b <= w_b_hit ? w_wdata : w_rd_b;
            r_out_valid  <= w_ld;
            r_addr_err   <= w_err;
        end
    end

    assign o_file_out   = r_file_out;
    assign o_file_out_b = r_file_out_b;
    assign o_out_valid  = r_out_valid;
    assign o_addr_err   = r_addr_err;
    assign o_busy       = r_state == S_SWEEP;
endmodule
